// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - instruction FIFO between fetch and decode with head-entry field split
module inst_decode_queue #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode_out,
    output logic [4:0]       rs_out,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic [4:0]       shamt_out,
    output logic [5:0]       funct_out,
    output logic [15:0]      imm_out,
    output logic [31:0]      imm_sext_out,
    output logic [31:0]      pc_plus4_out,
    output logic [31:0]      jump_addr_out,
    output logic             is_rtype_out,
    output logic [CNT_W-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head_inst;
    logic [31:0] w_head_pc4;

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count_out = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Entry storage has no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_inst[r_wr_ptr] <= in_inst;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_inst = r_inst[r_rd_ptr];
    assign w_head_pc4  = r_pc[r_rd_ptr] + 32'd4;

    // Decode fields are held at zero while the queue is empty so stale entries never leak.
    always_comb begin
        opcode_out    = '0;
        rs_out        = '0;
        rt_out        = '0;
        rd_out        = '0;
        shamt_out     = '0;
        funct_out     = '0;
        imm_out       = '0;
        imm_sext_out  = '0;
        pc_plus4_out  = '0;
        jump_addr_out = '0;
        is_rtype_out  = 1'b0;
        if (out_valid) begin
            opcode_out    = w_head_inst[31:26];
            rs_out        = w_head_inst[25:21];
            rt_out        = w_head_inst[20:16];
            rd_out        = w_head_inst[15:11];
            shamt_out     = w_head_inst[10:6];
            funct_out     = w_head_inst[5:0];
            imm_out       = w_head_inst[15:0];
            imm_sext_out  = {{16{w_head_inst[15]}}, w_head_inst[15:0]};
            pc_plus4_out  = w_head_pc4;
            jump_addr_out = {w_head_pc4[31:28], w_head_inst[25:0], 2'b00};
            is_rtype_out  = (w_head_inst[31:26] == 6'b000000);
        end
    end

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - table vectors plus scoreboard check of inst_decode_queue
module tb_inst_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]      in_inst, in_pc;
    logic [5:0]       opcode_out, funct_out;
    logic [4:0]       rs_out, rt_out, rd_out, shamt_out;
    logic [15:0]      imm_out;
    logic [31:0]      imm_sext_out, pc_plus4_out, jump_addr_out;
    logic             is_rtype_out;
    logic [CNT_W-1:0] count_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] model [$];

    inst_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_out(opcode_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .shamt_out(shamt_out), .funct_out(funct_out), .imm_out(imm_out),
        .imm_sext_out(imm_sext_out), .pc_plus4_out(pc_plus4_out),
        .jump_addr_out(jump_addr_out), .is_rtype_out(is_rtype_out), .count_out(count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        r;
        int          cnt;
        logic        ov;
        logic        ir;
        logic [5:0]  op;
        logic [4:0]  rs_f;
        logic [4:0]  rt_f;
        logic [4:0]  rd_f;
        logic [5:0]  fn;
        logic [31:0] sext;
        logic [31:0] pc4;
        logic [31:0] jmp;
        logic        rtype;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [159:0] dut_dec();
        return 160'({opcode_out, rs_out, rt_out, rd_out, shamt_out, funct_out, imm_out,
                     imm_sext_out, pc_plus4_out, jump_addr_out, is_rtype_out});
    endfunction

    function automatic logic [159:0] exp_dec(input logic [31:0] i, input logic [31:0] p, input bit valid);
        logic [31:0] p4;
        if (!valid) return '0;
        p4 = p + 32'd4;
        return 160'({i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0], i[15:0],
                     {{16{i[15]}}, i[15:0]}, p4, {p4[31:28], i[25:0], 2'b00},
                     (i[31:26] == 6'd0)});
    endfunction

    // Check the current head against the scoreboard, drive, predict, then advance one edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic r);
        logic [63:0] h;
        bit pu, po;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
        chk("sb_count", 160'(count_out), 160'(model.size()));
        chk("sb_in_ready", 160'(in_ready), 160'(model.size() < DEPTH));
        chk("sb_out_valid", 160'(out_valid), 160'(model.size() != 0));
        h = (model.size() != 0) ? model[0] : 64'd0;
        chk("sb_decode", dut_dec(), exp_dec(h[63:32], h[31:0], model.size() != 0));
        if (r || fl) begin
            model.delete();
        end else begin
            pu = v && (model.size() < DEPTH);
            po = ordy && (model.size() != 0);
            if (po) void'(model.pop_front());
            if (pu) model.push_back({inst, pc});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int k);
        return 32'h2100_8000 + 32'(k) * 32'h0421_0111;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1,
                   6'h0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h8C43_0010, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1,
                   6'h23, 5'd2, 5'd3, 5'd0, 6'h10, 32'h0000_0010, 32'h0040_0004, 32'h010C_0040, 1'b0};
        tbl[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1,
                   6'h0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[3] = '{1'b1, 32'h0085_2020, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1,
                   6'h00, 5'd4, 5'd5, 5'd4, 6'h20, 32'h0000_2020, 32'h0040_0008, 32'h0214_8080, 1'b1};
        tbl[4] = '{1'b1, 32'h2084_FFFC, 32'h0040_0008, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1,
                   6'h08, 5'd4, 5'd4, 5'd31, 6'h3C, 32'hFFFF_FFFC, 32'h0040_000C, 32'h0213_FFF0, 1'b0};
        tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1,
                   6'h0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[6] = '{1'b1, 32'h0810_0004, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1,
                   6'h02, 5'd0, 5'd16, 5'd0, 6'h04, 32'h0000_0004, 32'hF000_0004, 32'hF040_0010, 1'b0};
        tbl[7] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1,
                   6'h0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        model.delete();

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].r);
            chk($sformatf("v%0d_count", i), 160'(count_out), 160'(tbl[i].cnt));
            chk($sformatf("v%0d_out_valid", i), 160'(out_valid), 160'(tbl[i].ov));
            chk($sformatf("v%0d_in_ready", i), 160'(in_ready), 160'(tbl[i].ir));
            chk($sformatf("v%0d_fields", i), 160'({opcode_out, rs_out, rt_out, rd_out, funct_out}),
                160'({tbl[i].op, tbl[i].rs_f, tbl[i].rt_f, tbl[i].rd_f, tbl[i].fn}));
            chk($sformatf("v%0d_imm_sext", i), 160'(imm_sext_out), 160'(tbl[i].sext));
            chk($sformatf("v%0d_pc_plus4", i), 160'(pc_plus4_out), 160'(tbl[i].pc4));
            chk($sformatf("v%0d_jump", i), 160'(jump_addr_out), 160'(tbl[i].jmp));
            chk($sformatf("v%0d_rtype", i), 160'(is_rtype_out), 160'(tbl[i].rtype));
        end

        // Fill to full, then a pop while full must not admit the offered word.
        for (int k = 0; k < 4; k++) cycle(1'b1, word(k), 32'h0040_0100 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
        chk("full_count", 160'(count_out), 160'(4));
        chk("full_in_ready", 160'(in_ready), 160'(0));
        cycle(1'b1, word(4), 32'h0040_0110, 1'b1, 1'b0, 1'b0);
        chk("full_pop_count", 160'(count_out), 160'(3));
        chk("full_pop_in_ready", 160'(in_ready), 160'(1));
        chk("full_pop_head", 160'(pc_plus4_out), 160'(32'h0040_0108));
        cycle(1'b1, word(4), 32'h0040_0110, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, word(5), 32'h0040_0114, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, word(5), 32'h0040_0114, 1'b1, 1'b0, 1'b0);
        chk("wrap_count", 160'(count_out), 160'(3));
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Simultaneous push/pop at count 2, then flush with a word offered.
        cycle(1'b1, 32'h2401_0001, 32'h0040_1000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2402_0002, 32'h0040_1004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2403_0003, 32'h0040_1008, 1'b1, 1'b0, 1'b0);
        chk("simul_count", 160'(count_out), 160'(2));
        chk("simul_head", 160'(pc_plus4_out), 160'(32'h0040_1008));
        cycle(1'b1, 32'hDEAD_BEEF, 32'h0040_100C, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 160'(count_out), 160'(0));
        chk("flush_out_valid", 160'(out_valid), 160'(0));
        chk("flush_decode_zero", dut_dec(), 160'(0));
        cycle(1'b1, 32'h2405_0005, 32'h0040_1010, 1'b0, 1'b0, 1'b0);
        chk("post_flush_count", 160'(count_out), 160'(1));
        chk("post_flush_head", 160'({imm_out, pc_plus4_out}), 160'({16'h0005, 32'h0040_1014}));

        // Reset wins over flush and a push at count 3.
        cycle(1'b1, 32'h2406_0006, 32'h0040_1014, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2407_0007, 32'h0040_1018, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 160'(count_out), 160'(3));
        cycle(1'b1, 32'h2408_0008, 32'h0040_101C, 1'b1, 1'b1, 1'b1);
        chk("rst_count", 160'(count_out), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
